// File: rtl/problem5.sv
// problem5: registered 4-to-1 selector; i_ctrl picks one of four DATA_W-bit
// sources each i_clk edge into o_data; i_rst_n async active-low clears o_data.
module problem5 #(
  parameter int DATA_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [DATA_W-1:0] i_data_0,
  input  logic [DATA_W-1:0] i_data_1,
  input  logic [DATA_W-1:0] i_data_2,
  input  logic [DATA_W-1:0] i_data_3,
  input  logic [1:0]        i_ctrl,
  output logic [DATA_W-1:0] o_data
);

  logic [DATA_W-1:0] sel;

  // Default arm keeps the mux full even for X/Z select; output is a don't-care then.
  always_comb begin
    sel = i_data_0;
    case (i_ctrl)
      2'b00:   sel = i_data_0;
      2'b01:   sel = i_data_1;
      2'b10:   sel = i_data_2;
      2'b11:   sel = i_data_3;
      default: sel = i_data_0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_data <= '0;
    end else begin
      o_data <= sel;
    end
  end

endmodule

// File: tb/tb_problem5.sv
// tb_problem5: random and directed checks of problem5 against an
// array-indexed reference of the selected source.
module tb_problem5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] d [4];
  logic [1:0]  ctrl;
  logic [15:0] q;
  logic [15:0] exp_q;
  int          checks = 0;
  int          failures = 0;

  problem5 #(.DATA_W(16)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_data_0(d[0]),
    .i_data_1(d[1]),
    .i_data_2(d[2]),
    .i_data_3(d[3]),
    .i_ctrl  (ctrl),
    .o_data  (q)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set_in(input logic [1:0] c, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] e,
                        input logic [15:0] f);
    ctrl = c;
    d[0] = a;
    d[1] = b;
    d[2] = e;
    d[3] = f;
  endtask

  // Drive at the falling edge, capture on the next rising edge, check after it.
  task automatic step(input string tag, input logic [1:0] c,
                      input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] e, input logic [15:0] f);
    @(negedge clk);
    set_in(c, a, b, e, f);
    exp_q = d[c];
    @(posedge clk);
    #1;
    chk(tag, q, exp_q);
  endtask

  initial begin
    logic [1:0] rc;
    set_in(2'b11, 16'h0000, 16'h0000, 16'h0000, 16'hf000);

    // Held reset with clock running
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("rst_hold", q, 16'h0000);
    end
    @(negedge clk);
    chk("rst_hold_neg", q, 16'h0000);
    #1 rst_n = 1'b1;
    #1 chk("rst_release_noedge", q, 16'h0000);
    @(posedge clk);
    #1 chk("rst_first_capture", q, 16'hf000);

    // Select sweep
    for (int i = 0; i < 4; i++) begin
      rc = 2'(i);
      step("sweep", rc, 16'h000f, 16'h00f0, 16'h0f00, 16'hf000);
    end

    // Mid-cycle select change does not reach o_data before the edge
    step("lat_pre", 2'b00, 16'h000f, 16'h00f0, 16'h0f00, 16'hf000);
    @(negedge clk);
    ctrl = 2'b10;
    #2 chk("lat_hold", q, 16'h000f);
    @(posedge clk);
    #1 chk("lat_edge", q, 16'h0f00);

    // Async reset mid-run
    #1 rst_n = 1'b0;
    #1 chk("arst_immediate", q, 16'h0000);
    @(negedge clk);
    chk("arst_held", q, 16'h0000);
    #1 rst_n = 1'b1;
    #1 chk("arst_release_noedge", q, 16'h0000);
    @(posedge clk);
    #1 chk("arst_resume", q, 16'h0f00);

    // Fixed select data tracking, unselected inputs wiggled
    step("track0", 2'b01, 16'haaaa, 16'h1234, 16'h5555, 16'h7777);
    step("track1", 2'b01, 16'h0101, 16'hffff, 16'h2222, 16'h8888);
    step("track_hold", 2'b01, 16'h3333, 16'hffff, 16'h4444, 16'h9999);
    @(negedge clk);
    d[0] = 16'hdead;
    d[2] = 16'hbeef;
    d[3] = 16'hcafe;
    #2 chk("unsel_noedge", q, 16'hffff);
    @(posedge clk);
    #1 chk("unsel_edge", q, 16'hffff);

    // Back-to-back alternation
    for (int i = 0; i < 8; i++) begin
      rc = (i % 2 == 0) ? 2'b00 : 2'b11;
      step("alt", rc, 16'h000f, 16'h00f0, 16'h0f00, 16'hf000);
    end

    // Random traffic with occasional mid-cycle reset pulses
    for (int i = 0; i < 300; i++) begin
      rc = 2'($urandom_range(0, 3));
      step("rand", rc, 16'($urandom), 16'($urandom),
           16'($urandom), 16'($urandom));
      if ($urandom_range(0, 7) == 0) begin
        #1 rst_n = 1'b0;
        #1 chk("rand_arst", q, 16'h0000);
        #1 rst_n = 1'b1;
        #1 chk("rand_arst_rel", q, 16'h0000);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
